round_sequencer: RTL and testbench

//  Parametrised cipher round sequencer, next generation of the fixed 16-round counter.

---
 rtl/round_sequencer.sv | 145 ++++++++++++++
 tb/tb_round_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// Cipher round sequencer.
// Steps a round index from 0 up to a key-size-dependent terminal round and
// flags the first and last rounds for the round datapath and key expansion.
// A start/done handshake frames each sequence. A per-cycle stall holds the
// sequence, and abort cancels it. Every output is a flop, so no input has a
// combinational path to an output.
module round_sequencer #(
    parameter int CNT_W      = 5,
    parameter int ROUNDS_128 = 10,
    parameter int ROUNDS_192 = 12,
    parameter int ROUNDS_256 = 14,
    parameter int ROUNDS_ALT = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             stall,
    input  logic             abort,
    input  logic [1:0]       key_mode,
    output logic [CNT_W-1:0] round_count,
    output logic             round_first,
    output logic             round_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] term_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TERM_128 = CNT_W'(ROUNDS_128);
    localparam logic [CNT_W-1:0] TERM_192 = CNT_W'(ROUNDS_192);
    localparam logic [CNT_W-1:0] TERM_256 = CNT_W'(ROUNDS_256);
    localparam logic [CNT_W-1:0] TERM_ALT = CNT_W'(ROUNDS_ALT);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] count_nx;
    logic [CNT_W-1:0] term_nx;
    logic [CNT_W-1:0] term_sel;
    logic             accept;

    // Terminal round for the key size currently on the key_mode pins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        term_sel = TERM_128;
        case (key_mode)
            2'b00:   term_sel = TERM_128;
            2'b01:   term_sel = TERM_192;
            2'b10:   term_sel = TERM_256;
            default: term_sel = TERM_ALT;
        endcase
    end

    // A new sequence may only begin from IDLE or DONE, and abort overrides it.
    assign accept = start && !abort && (state == IDLE || state == DONE);

    // Next state, round index and latched terminal round.
    // Priority is abort, then start, then stall.
    always_comb begin
        state_nx = state;
        count_nx = round_count;
        term_nx  = term_count;
        if (abort) begin
            state_nx = IDLE;
            count_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    count_nx = '0;
                    if (accept) begin
                        state_nx = RUN;
                        term_nx  = term_sel;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        if (round_count < term_count) begin
                            count_nx = round_count + 1'b1;
                        end else begin
                            // Final round finished. The index stays at term
                            // for the single DONE cycle.
                            state_nx = DONE;
                        end
                    end
                end
                DONE: begin
                    count_nx = '0;
                    if (accept) begin
                        // Back-to-back sequence. key_mode is sampled again here.
                        state_nx = RUN;
                        term_nx  = term_sel;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    count_nx = '0;
                end
            endcase
        end
    end

    // State and output registers. The flags are computed from the next
    // state and index, so they are flops rather than decodes of inputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            round_count <= '0;
            term_count  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            round_first <= 1'b0;
            round_last  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // flop samples the values from before this edge.
            state       <= state_nx;
            round_count <= count_nx;
            term_count  <= term_nx;
            busy        <= (state_nx == RUN);
            done        <= (state_nx == DONE);
            round_first <= (state_nx == RUN) && (count_nx == '0);
            round_last  <= (state_nx == RUN) && (count_nx == term_nx);
        end
    end

    // The round index never passes the latched terminal round.
    a_count_bounded: assert property (@(posedge clk) disable iff (!n_rst)
        busy |-> (round_count <= term_count));

    // The done pulse lasts exactly one cycle.
    a_done_single: assert property (@(posedge clk) disable iff (!n_rst)
        done |=> !done);

    // busy and done are never high together.
    a_busy_done_excl: assert property (@(posedge clk) disable iff (!n_rst)
        !(busy && done));

endmodule

// File: tb/tb_round_sequencer.sv
// Testbench for round_sequencer.
// A queue-based model expands each accepted start into the full list of
// per-cycle expected outputs. A compare process checks the DUT against the
// head of that list on every falling edge. Directed scenarios add
// hand-computed literal checks that pin the model itself.
module tb_round_sequencer;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             n_rst;
    logic             start;
    logic             stall;
    logic             abort;
    logic [1:0]       key_mode;
    logic [CNT_W-1:0] round_count;
    logic             round_first;
    logic             round_last;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] term_count;

    int vectors = 0;
    int errors  = 0;

    round_sequencer #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .stall       (stall),
        .abort       (abort),
        .key_mode    (key_mode),
        .round_count (round_count),
        .round_first (round_first),
        .round_last  (round_last),
        .busy        (busy),
        .done        (done),
        .term_count  (term_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rounds_for(input logic [1:0] m);
        case (m)
            2'b00:   return 10;
            2'b01:   return 12;
            2'b10:   return 14;
            default: return 16;
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    // Each entry is one cycle of expected output. An accepted start appends
    // term+1 busy entries followed by one done entry.
    typedef struct {
        int cnt;
        bit bsy;
        bit dn;
        int term;
    } exp_t;

    exp_t q[$];
    int   m_term;
    int   m_t;
    bit   m_cur_busy;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            q.delete();
            m_term = 0;
        end else begin
            m_cur_busy = (q.size() > 0) && q[0].bsy;
            if (abort) begin
                q.delete();
            end else if (!(m_cur_busy && stall)) begin
                if (q.size() > 0) void'(q.pop_front());
                if (!m_cur_busy && start) begin
                    m_t = rounds_for(key_mode);
                    for (int r = 0; r <= m_t; r++) q.push_back('{r, 1'b1, 1'b0, m_t});
                    q.push_back('{m_t, 1'b0, 1'b1, m_t});
                    m_term = m_t;
                end
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) e = q[0];
        else e = '{0, 1'b0, 1'b0, 0};
        check("round_count", 32'(round_count), e.cnt);
        check("busy",        32'(busy),        32'(e.bsy));
        check("done",        32'(done),        32'(e.dn));
        check("round_first", 32'(round_first), 32'(e.bsy && e.cnt == 0));
        check("round_last",  32'(round_last),  32'(e.bsy && e.cnt == e.term));
        check("term_count",  32'(term_count),  m_term);
    end

    // ---------------- stimulus helpers ----------------
    // Starts one sequence and follows it until IDLE. The task can stall for
    // stall_len cycles at index stall_at and can abort at index abort_at.
    // It records busy and done cycle counts and the busy-cycle index of the
    // first round_first and the first round_last.
    task automatic run_seq(input logic [1:0] mode, input int stall_at, input int stall_len,
                           input int abort_at, output int busy_cyc, output int done_cyc,
                           output int first_at, output int last_at);
        int  stalls_left = -1;
        bit  ended = 1'b0;
        @(negedge clk);
        start    = 1'b1;
        key_mode = mode;
        @(negedge clk);
        start    = 1'b0;
        key_mode = mode ^ 2'b01;  // changes while RUN must have no effect
        busy_cyc = 0;
        done_cyc = 0;
        first_at = -1;
        last_at  = -1;
        for (int c = 0; c < 100; c++) begin
            stall = 1'b0;
            abort = 1'b0;
            if (done) done_cyc++;
            if (!busy && !done) begin
                ended = 1'b1;
                break;
            end
            if (busy) begin
                if (round_first && first_at < 0) first_at = busy_cyc;
                if (round_last && last_at < 0) last_at = busy_cyc;
                busy_cyc++;
                if (round_count == stall_at && stalls_left < 0) stalls_left = stall_len;
                if (stalls_left > 0) begin
                    stall = 1'b1;
                    stalls_left--;
                end
                if (round_count == abort_at) abort = 1'b1;
            end
            @(negedge clk);
        end
        stall = 1'b0;
        abort = 1'b0;
        check("run_seq_reached_idle", 32'(ended), 1);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int bc, dc, fa, la, seen;
        int exp_busy[4];
        exp_busy = '{11, 13, 15, 17};

        n_rst = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        abort = 1'b0;
        key_mode = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_count", 32'(round_count), 0);
        check("reset_term",  32'(term_count),  0);
        check("reset_flags", {28'd0, busy, done, round_first, round_last}, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: 128-bit mode, unstalled.
        run_seq(2'b00, -1, 0, -1, bc, dc, fa, la);
        check("t1_busy_cycles", bc, 11);
        check("t1_done_cycles", dc, 1);
        check("t1_first_at",    fa, 0);
        check("t1_last_at",     la, 10);
        check("t1_term_held",   32'(term_count), 10);

        // Test 2: the other key sizes.
        for (int m = 1; m < 4; m++) begin
            run_seq(2'(m), -1, 0, -1, bc, dc, fa, la);
            check("t2_busy_cycles", bc, exp_busy[m]);
            check("t2_done_cycles", dc, 1);
            check("t2_last_at",     la, exp_busy[m] - 1);
            check("t2_term",        32'(term_count), exp_busy[m] - 1);
        end

        // Test 3: 256-bit mode, stall 3 cycles at index 5.
        run_seq(2'b10, 5, 3, -1, bc, dc, fa, la);
        check("t3_busy_cycles", bc, 18);
        check("t3_last_at",     la, 17);
        check("t3_done_cycles", dc, 1);

        // Stall on round 0, then on the final round.
        run_seq(2'b00, 0, 2, -1, bc, dc, fa, la);
        check("stall_r0_busy", bc, 13);
        check("stall_r0_last", la, 12);
        run_seq(2'b00, 10, 1, -1, bc, dc, fa, la);
        check("stall_last_busy", bc, 12);
        check("stall_last_at",   la, 10);

        // Test 4: abort at index 7.
        run_seq(2'b00, -1, 0, 7, bc, dc, fa, la);
        check("t4_busy_cycles", bc, 8);
        check("t4_no_done",     dc, 0);
        check("t4_count_idle",  32'(round_count), 0);

        // abort beats start in IDLE.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", 32'(busy), 0);

        // Test 5: start held through DONE gives back-to-back runs.
        @(negedge clk);
        start    = 1'b1;
        key_mode = 2'b00;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check("t5_done_seen", seen, 1);
        check("t5_term_run1", 32'(term_count), 10);
        key_mode = 2'b01;
        @(negedge clk);
        check("t5_rerun_busy",  32'(busy),        1);
        check("t5_rerun_count", 32'(round_count), 0);
        check("t5_rerun_first", 32'(round_first), 1);
        check("t5_rerun_term",  32'(term_count),  12);
        start = 1'b0;
        dc = 0;
        bc = 1;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (done) dc++;
            if (busy) bc++;
            if (!busy && !done) begin
                seen = 1;
                break;
            end
        end
        check("t5_reached_idle", seen, 1);
        check("t5_busy_run2",    bc, 13);
        check("t5_done_run2",    dc, 1);

        // Test 6: asynchronous reset at index 9 of a 14-round run.
        @(negedge clk);
        start    = 1'b1;
        key_mode = 2'b10;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (round_count == 9) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        check("t6_reached_9", seen, 1);
        #2 n_rst = 1'b0;
        #1;
        check("t6_async_count", 32'(round_count), 0);
        check("t6_async_term",  32'(term_count),  0);
        check("t6_async_flags", {28'd0, busy, done, round_first, round_last}, 0);
        @(negedge clk);
        n_rst = 1'b1;
        dc = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy) dc++;
        end
        check("t6_idle_after", dc, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
